// File: rtl/vote_pkg.sv
// vote_pkg: shared types and helpers for the serial ballot sequencer.
//   vote_state_t : sequencer FSM encoding (IDLE, COLLECT, DONE)
//   cnt_w(n)     : counter width able to hold 0..n
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } vote_state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vote_tally.sv
// vote_tally: counts accepted votes and accepted ones for one ballot.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   clear        : zero both counters (wins over inc)
//   inc          : one vote accepted this cycle
//   vote_bit     : value of the accepted vote
//   votes, ones  : registered counts
//   last         : this accept is the final vote of the ballot
module vote_tally
    import vote_pkg::*;
#(
    parameter int NVOTES = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      inc,
    input  logic                      vote_bit,
    output logic [cnt_w(NVOTES)-1:0]  votes,
    output logic [cnt_w(NVOTES)-1:0]  ones,
    output logic                      last
);

    localparam int CW = cnt_w(NVOTES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            votes <= '0;
            ones  <= '0;
        end else if (clear) begin
            votes <= '0;
            ones  <= '0;
        end else if (inc) begin
            votes <= votes + CW'(1);
            ones  <= ones + CW'(vote_bit);
        end
    end

    assign last = inc && (votes == CW'(NVOTES - 1));

endmodule

// File: rtl/vote_sequencer.sv
// vote_sequencer: runs one ballot of NVOTES serial votes through the
// minority/majority function and holds the verdict until it is taken.
// Optional feature: define VOTE_TIMEOUT_EN to end a stalled ballot after
// TIMEOUT idle cycles with result_timeout=1 and both verdicts 0.
// Ports:
//   clk, reset_n                 : clock, async active-low reset
//   start, abort                 : begin ballot (IDLE only) / synchronous abort
//   vote_valid, vote_bit, vote_ready : vote handshake (ready exactly in COLLECT)
//   busy                         : COLLECT or DONE
//   result_valid, result_ready   : verdict handshake (valid exactly in DONE)
//   result_minority/majority/timeout : verdict, held through back-pressure
module vote_sequencer
    import vote_pkg::*;
#(
    parameter int NVOTES  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic abort,
    input  logic vote_valid,
    input  logic vote_bit,
    output logic vote_ready,
    output logic busy,
    output logic result_valid,
    input  logic result_ready,
    output logic result_minority,
    output logic result_majority,
    output logic result_timeout
);

    localparam int CW = cnt_w(NVOTES);

    if (NVOTES < 3 || (NVOTES % 2) == 0) begin : g_bad_nvotes
        $error("vote_sequencer: NVOTES must be odd and >= 3");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("vote_sequencer: TIMEOUT must be >= 2");
    end

    vote_state_t state_q, state_d;

    logic          in_collect, inc, tally_clear, last, handoff;
    logic [CW-1:0] unused_votes, ones, ones_upd;
    logic          verdict_min, timeout_hit;
    logic          res_min_q, res_maj_q, res_to_q;

    assign in_collect  = (state_q == COLLECT);
    // abort outranks the vote handshake: an aborted vote is never counted
    assign inc         = vote_valid & in_collect & ~abort;
    // counts only live inside COLLECT, so leaving it always starts clean
    assign tally_clear = ~in_collect | abort;
    assign handoff     = (state_q == DONE) & result_ready;

    vote_tally #(.NVOTES(NVOTES)) u_tally (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (tally_clear),
        .inc      (inc),
        .vote_bit (vote_bit),
        .votes    (unused_votes),
        .ones     (ones),
        .last     (last)
    );

    // verdict must include the vote being accepted on the final cycle
    assign ones_upd    = ones + CW'(vote_bit);
    assign verdict_min = (ones_upd <= CW'(NVOTES / 2));

`ifdef VOTE_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT);
    logic [IW-1:0] idle_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            idle_q <= '0;
        else if (!in_collect || abort || inc)
            idle_q <= '0;
        else
            idle_q <= idle_q + IW'(1);
    end

    // an accept in the same cycle wins, so inc masks the expiry
    assign timeout_hit = in_collect & ~abort & ~inc & (idle_q == IW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = COLLECT;
                COLLECT: if (last || timeout_hit) state_d = DONE;
                DONE:    if (result_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            res_min_q <= 1'b0;
            res_maj_q <= 1'b0;
            res_to_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (abort || handoff) begin
                res_min_q <= 1'b0;
                res_maj_q <= 1'b0;
                res_to_q  <= 1'b0;
            end else if (last) begin
                res_min_q <= verdict_min;
                res_maj_q <= ~verdict_min;
                res_to_q  <= 1'b0;
            end else if (timeout_hit) begin
                res_min_q <= 1'b0;
                res_maj_q <= 1'b0;
                res_to_q  <= 1'b1;
            end
        end
    end

    assign vote_ready      = in_collect;
    assign busy            = (state_q != IDLE);
    assign result_valid    = (state_q == DONE);
    assign result_minority = res_min_q;
    assign result_majority = res_maj_q;
    assign result_timeout  = res_to_q;

endmodule

// File: tb/tb_vote_sequencer.sv
// tb_vote_sequencer: directed vectors with hand-computed expectations for
// vote_sequencer (NVOTES=3, TIMEOUT=15). Timeout vectors apply when
// VOTE_TIMEOUT_EN is defined; otherwise the indefinite wait is checked.
module tb_vote_sequencer;

    logic clk = 1'b0, reset_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, vote_valid = 1'b0, vote_bit = 1'b0;
    logic result_ready = 1'b0;
    logic vote_ready, busy, result_valid;
    logic result_minority, result_majority, result_timeout;

    int n_chk = 0, n_pass = 0, n_acc = 0, n0 = 0;

    vote_sequencer #(.NVOTES(3), .TIMEOUT(15)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .vote_valid      (vote_valid),
        .vote_bit        (vote_bit),
        .vote_ready      (vote_ready),
        .busy            (busy),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_minority (result_minority),
        .result_majority (result_majority),
        .result_timeout  (result_timeout)
    );

    always #5 clk = ~clk;

    // handshake-level accept counter
    always @(posedge clk) if (vote_valid && vote_ready) n_acc <= n_acc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_ballot();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic vote(input logic b);
        vote_valid = 1'b1;
        vote_bit   = b;
        tick();
        vote_valid = 1'b0;
    endtask

    task automatic take_result();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        // 1: reset
        #2;
        chk("rst_outs", 32'({vote_ready, busy, result_valid, result_minority,
                             result_majority, result_timeout}), 32'd0);
        #10 reset_n = 1'b1;
        tick();
        start_ballot();
        chk("t1_collect", 32'(vote_ready), 32'd1);
        vote(1'b1);
        reset_n = 1'b0;
        #1;
        chk("t1_rst_mid", 32'({vote_ready, busy, result_valid, result_minority,
                               result_majority, result_timeout}), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t1_idle", 32'({busy, vote_ready}), 32'd0);

        // 2: votes 0,0,1 back to back -> minority
        start_ballot();
        chk("t2_ready", 32'(vote_ready), 32'd1);
        vote_valid = 1'b1;
        vote_bit = 1'b0; tick();
        vote_bit = 1'b0; tick();
        chk("t2_not_yet", 32'(result_valid), 32'd0);
        vote_bit = 1'b1; tick();
        vote_valid = 1'b0;
        chk("t2_verdict", 32'({result_valid, result_minority, result_majority,
                               result_timeout, vote_ready}), 32'b11000);
        take_result();
        chk("t2_idle", 32'({busy, result_valid}), 32'd0);

        // 3: votes 1,0,1 under back-pressure -> majority held
        start_ballot();
        vote_valid = 1'b1;
        vote_bit = 1'b1; tick();
        vote_bit = 1'b0; tick();
        vote_bit = 1'b1; tick();
        vote_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold", 32'({result_valid, result_minority, result_majority}), 32'b101);
            tick();
        end
        chk("t3_still_done", 32'({result_valid, result_majority}), 32'b11);
        // start coinciding with handoff is ignored
        start = 1'b1;
        take_result();
        start = 1'b0;
        chk("t3_handoff", 32'({busy, result_valid}), 32'd0);
        tick();
        chk("t3_start_ignored", 32'({busy, vote_ready}), 32'd0);

        // 4: gapped votes 1,1,1; vote_valid outside COLLECT accepts nothing
        n0 = n_acc;
        vote_valid = 1'b1; vote_bit = 1'b1;
        tick(); tick();
        vote_valid = 1'b0;
        chk("t4_idle_noacc", 32'(n_acc - n0), 32'd0);
        start_ballot();
        for (int k = 0; k < 3; k++) begin
            vote(1'b1);
            if (k < 2) begin
                tick(); tick(); tick();
            end
        end
        chk("t4_accepts", 32'(n_acc - n0), 32'd3);
        chk("t4_verdict", 32'({result_valid, result_minority, result_majority}), 32'b101);
        vote_valid = 1'b1;
        tick(); tick();
        vote_valid = 1'b0;
        chk("t4_done_noacc", 32'(n_acc - n0), 32'd3);
        chk("t4_done_hold", 32'(result_valid), 32'd1);
        take_result();

        // 5: abort with 2nd vote, then fresh ballot 0,0,0
        start_ballot();
        vote(1'b1);
        vote_valid = 1'b1; vote_bit = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0; vote_valid = 1'b0;
        chk("t5_aborted", 32'({busy, result_valid, vote_ready}), 32'd0);
        tick();
        chk("t5_no_verdict", 32'(result_valid), 32'd0);
        start_ballot();
        vote(1'b0);
        vote(1'b0);
        chk("t5_fresh_count", 32'(result_valid), 32'd0);
        vote(1'b0);
        chk("t5_verdict", 32'({result_valid, result_minority, result_majority}), 32'b110);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_abort_done", 32'({busy, result_valid, result_minority}), 32'd0);
        start = 1'b1; abort = 1'b1; tick();
        start = 1'b0; abort = 1'b0;
        chk("t5_abort_over_start", 32'(busy), 32'd0);

`ifdef VOTE_TIMEOUT_EN
        // 6: timeout on the 15th idle cycle
        start_ballot();
        vote(1'b1);
        repeat (14) tick();
        chk("t6_before_to", 32'({busy, result_valid}), 32'b10);
        tick();
        chk("t6_timeout", 32'({result_valid, result_timeout, result_minority,
                               result_majority}), 32'b1100);
        take_result();
        // accept on the expiry cycle wins and restarts the count
        start_ballot();
        vote(1'b1);
        repeat (14) tick();
        vote(1'b0);
        chk("t6_accept_wins", 32'({busy, result_valid}), 32'b10);
        repeat (14) tick();
        chk("t6_restart", 32'(result_valid), 32'd0);
        tick();
        chk("t6_timeout2", 32'({result_valid, result_timeout, result_minority,
                                result_majority}), 32'b1100);
        take_result();
`else
        // 6: without the timeout the ballot waits indefinitely
        start_ballot();
        vote(1'b1);
        repeat (20) tick();
        chk("t6_wait", 32'({busy, result_valid, result_timeout}), 32'b100);
        abort = 1'b1; tick(); abort = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
